// File: rtl/nav_pkg.sv
// Shared types and speed constants for the navigation sequencer.
// States of the motion FSM plus default forward-speed profile.
package nav_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADING,
    RAMP_UP,
    RAMP_DOWN,
    DECEL_FAST
  } nav_state_t;

  localparam logic [10:0] MIN_FRWRD = 11'h0D0;
  localparam logic [10:0] MAX_FRWRD = 11'h2A0;
  localparam logic [5:0]  FRWRD_INC = 6'h18;

endpackage

// File: rtl/spd_ramp.sv
// Forward-speed register with saturating ramp steps taken on hdng_vld.
// Ports: clk, rst_n (sync, active-low), step controls in, frwrd_spd out.
module spd_ramp
  import nav_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_min,
  input  logic        inc,
  input  logic        dec,
  input  logic        dec_fast,
  input  logic        clr,
  input  logic        hdng_vld,
  output logic [10:0] frwrd_spd
);

  logic [10:0]        spd_q;
  logic [10:0]        spd_d;
  logic [11:0]        sum;
  logic [11:0]        step;
  logic signed [11:0] diff;

  always_comb begin
    step = dec_fast ? {4'b0, FRWRD_INC, 2'b0}
                    : {5'b0, FRWRD_INC, 1'b0};
    sum  = {1'b0, spd_q} + {6'b0, FRWRD_INC};
    diff = $signed({1'b0, spd_q}) - $signed(step);
    spd_d = spd_q;
    if (clr) begin
      spd_d = '0;
    end else if (load_min) begin
      spd_d = MIN_FRWRD;
    end else if (hdng_vld) begin
      if (inc) begin
        spd_d = (sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD
                                          : sum[10:0];
      end else if (dec | dec_fast) begin
        // negative result means we overshot zero
        spd_d = diff[11] ? '0 : diff[10:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spd_q <= '0;
    end else begin
      spd_q <= spd_d;
    end
  end

  assign frwrd_spd = spd_q;

endmodule

// File: rtl/navigate_ctrl.sv
// Motion sequencer feeding moving/frwrd_spd to the heading PID.
// Ports: commands, wall/opening sensors in; moving, speed, fusion, done out.
module navigate_ctrl
  import nav_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_hdng,
  input  logic        strt_mv,
  input  logic        stp_lft,
  input  logic        stp_rght,
  input  logic        hdng_vld,
  input  logic        at_hdng,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  output logic        moving,
  output logic [10:0] frwrd_spd,
  output logic        en_fusion,
  output logic        mv_cmplt
);

  nav_state_t state_q, state_d;
  logic moving_q, moving_d;
  logic mv_cmplt_q, mv_cmplt_d;
  logic en_fusion_q, en_fusion_d;
  logic stp_lft_q, stp_lft_d;
  logic stp_rght_q, stp_rght_d;
  logic lft_opn_q, lft_opn_d;
  logic rght_opn_q, rght_opn_d;
  logic load_min, inc, dec, dec_fast, clr;
  logic opn_edge;
  logic [10:0] spd;

  spd_ramp u_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_min (load_min),
    .inc      (inc),
    .dec      (dec),
    .dec_fast (dec_fast),
    .clr      (clr),
    .hdng_vld (hdng_vld),
    .frwrd_spd(spd)
  );

  // edge taken on the raw opening so one present at
  // strt_mv cannot look like a fresh opening
  assign opn_edge =
    (lft_opn & ~lft_opn_q & stp_lft_q) |
    (rght_opn & ~rght_opn_q & stp_rght_q);

  always_comb begin
    state_d     = state_q;
    moving_d    = moving_q;
    mv_cmplt_d  = 1'b0;
    en_fusion_d = spd > (MAX_FRWRD >> 1);
    stp_lft_d   = stp_lft_q;
    stp_rght_d  = stp_rght_q;
    lft_opn_d   = lft_opn;
    rght_opn_d  = rght_opn;
    load_min    = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;
    dec_fast    = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr      = 1'b1;
        moving_d = 1'b0;
        if (strt_hdng) begin
          state_d  = HEADING;
          moving_d = 1'b1;
        end else if (strt_mv) begin
          if (frwrd_opn) begin
            state_d    = RAMP_UP;
            moving_d   = 1'b1;
            clr        = 1'b0;
            load_min   = 1'b1;
            stp_lft_d  = stp_lft;
            stp_rght_d = stp_rght;
          end else begin
            mv_cmplt_d = 1'b1;
          end
        end
      end
      HEADING: begin
        if (at_hdng & hdng_vld) begin
          state_d    = IDLE;
          moving_d   = 1'b0;
          mv_cmplt_d = 1'b1;
        end
      end
      RAMP_UP: begin
        inc = 1'b1;
        if (!frwrd_opn) begin
          state_d = DECEL_FAST;
        end else if (opn_edge) begin
          state_d = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        dec = 1'b1;
        if (spd == '0) begin
          state_d    = IDLE;
          moving_d   = 1'b0;
          mv_cmplt_d = 1'b1;
        end else if (!frwrd_opn) begin
          state_d = DECEL_FAST;
        end
      end
      DECEL_FAST: begin
        dec_fast = 1'b1;
        if (spd == '0) begin
          state_d    = IDLE;
          moving_d   = 1'b0;
          mv_cmplt_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        moving_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      moving_q    <= 1'b0;
      mv_cmplt_q  <= 1'b0;
      en_fusion_q <= 1'b0;
      stp_lft_q   <= 1'b0;
      stp_rght_q  <= 1'b0;
      lft_opn_q   <= 1'b0;
      rght_opn_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      moving_q    <= moving_d;
      mv_cmplt_q  <= mv_cmplt_d;
      en_fusion_q <= en_fusion_d;
      stp_lft_q   <= stp_lft_d;
      stp_rght_q  <= stp_rght_d;
      lft_opn_q   <= lft_opn_d;
      rght_opn_q  <= rght_opn_d;
    end
  end

  assign moving    = moving_q;
  assign frwrd_spd = spd;
  assign en_fusion = en_fusion_q;
  assign mv_cmplt  = mv_cmplt_q;

endmodule

// File: tb/tb_navigate_ctrl.sv
// Bench for navigate_ctrl: directed stimulus, reference model, literals.
// Drives on negedge, model steps on posedge, compares on negedge.
module tb_navigate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_hdng = 1'b0;
  logic        strt_mv = 1'b0;
  logic        stp_lft = 1'b0;
  logic        stp_rght = 1'b0;
  logic        hdng_vld = 1'b0;
  logic        at_hdng = 1'b0;
  logic        lft_opn = 1'b0;
  logic        rght_opn = 1'b0;
  logic        frwrd_opn = 1'b1;
  logic        moving;
  logic [10:0] frwrd_spd;
  logic        en_fusion;
  logic        mv_cmplt;

  navigate_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_hdng(strt_hdng),
    .strt_mv  (strt_mv),
    .stp_lft  (stp_lft),
    .stp_rght (stp_rght),
    .hdng_vld (hdng_vld),
    .at_hdng  (at_hdng),
    .lft_opn  (lft_opn),
    .rght_opn (rght_opn),
    .frwrd_opn(frwrd_opn),
    .moving   (moving),
    .frwrd_spd(frwrd_spd),
    .en_fusion(en_fusion),
    .mv_cmplt (mv_cmplt)
  );

  always #5 clk = ~clk;

  localparam int MINS = 208;
  localparam int MAXS = 672;
  localparam int INC  = 24;

  // model activity: what the robot is doing
  localparam int PI = 0;
  localparam int PT = 1;
  localparam int PA = 2;
  localparam int PD = 3;
  localparam int PF = 4;

  int n_chk = 0;
  int n_fail = 0;
  int n_cmplt = 0;
  bit chk_on = 0;

  int ph = PI;
  int m_spd = 0;
  int m_mov = 0;
  int m_cm = 0;
  int m_en = 0;
  int sl = 0, sr = 0, pl = 0, pr = 0;
  int o;
  bit rise;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = PI; m_spd = 0; m_mov = 0; m_cm = 0; m_en = 0;
      sl = 0; sr = 0; pl = 0; pr = 0;
    end else begin
      o = m_spd;
      rise = (lft_opn && !pl && sl != 0) ||
             (rght_opn && !pr && sr != 0);
      m_en = (o > MAXS / 2) ? 1 : 0;
      m_cm = 0;
      case (ph)
        PI: begin
          m_spd = 0;
          if (strt_hdng) begin
            ph = PT; m_mov = 1;
          end else if (strt_mv) begin
            if (frwrd_opn) begin
              ph = PA; m_mov = 1; m_spd = MINS;
              sl = int'(stp_lft); sr = int'(stp_rght);
            end else m_cm = 1;
          end
        end
        PT: if (at_hdng && hdng_vld) begin
          ph = PI; m_mov = 0; m_cm = 1;
        end
        PA: begin
          if (hdng_vld)
            m_spd = (o + INC > MAXS) ? MAXS : o + INC;
          if (!frwrd_opn) ph = PF;
          else if (rise) ph = PD;
        end
        PD: begin
          if (hdng_vld) m_spd = (o > 2*INC) ? o - 2*INC : 0;
          if (o == 0) begin
            ph = PI; m_mov = 0; m_cm = 1;
          end else if (!frwrd_opn) ph = PF;
        end
        default: begin
          if (hdng_vld) m_spd = (o > 4*INC) ? o - 4*INC : 0;
          if (o == 0) begin
            ph = PI; m_mov = 0; m_cm = 1;
          end
        end
      endcase
      pl = int'(lft_opn); pr = int'(rght_opn);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("moving", int'(moving), m_mov);
      chk("frwrd_spd", int'(frwrd_spd), m_spd);
      chk("en_fusion", int'(en_fusion), m_en);
      chk("mv_cmplt", int'(mv_cmplt), m_cm);
      if (mv_cmplt) n_cmplt++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic vld();
    hdng_vld = 1'b1;
    @(negedge clk);
    hdng_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic go_mv(input logic l);
    stp_lft = l;
    strt_mv = 1'b1;
    @(negedge clk);
    strt_mv = 1'b0;
    stp_lft = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c0;
    int e;
    repeat (2) step();
    chk_on = 1;
    chk("rst_spd", int'(frwrd_spd), 0);
    chk("rst_moving", int'(moving), 0);
    rst_n = 1'b1;
    step();

    // heading change
    strt_hdng = 1'b1; step(); strt_hdng = 1'b0;
    chk("hdg_moving", int'(moving), 1);
    repeat (8) step();
    vld();
    chk("hdg_wait", int'(moving), 1);
    c0 = n_cmplt;
    at_hdng = 1'b1; hdng_vld = 1'b1; step();
    hdng_vld = 1'b0; at_hdng = 1'b0;
    chk("hdg_cmplt", int'(mv_cmplt), 1);
    chk("hdg_stop", int'(moving), 0);
    step();
    chk("hdg_pulse_w", n_cmplt - c0, 1);

    // ramp up, stop on left opening
    go_mv(1'b1);
    chk("mv_min", int'(frwrd_spd), 'h0D0);
    for (int k = 1; k <= 25; k++) begin
      if (k == 4) go_mv(1'b0);
      vld();
      e = MINS + INC * k;
      if (e > MAXS) e = MAXS;
      chk("ramp_up", int'(frwrd_spd), e);
      if (k == 1) chk("up1", int'(frwrd_spd), 'h0E8);
      if (k == 5) chk("fus_off", int'(en_fusion), 0);
      if (k == 6) chk("fus_on", int'(en_fusion), 1);
      if (k == 19) chk("up19", int'(frwrd_spd), 'h298);
      if (k == 20) chk("sat", int'(frwrd_spd), 'h2A0);
    end
    lft_opn = 1'b1; step();
    c0 = n_cmplt;
    for (int k = 1; k <= 14; k++) begin
      vld();
      chk("ramp_dn", int'(frwrd_spd), MAXS - 48 * k);
    end
    step();
    chk("dn_cmplt", n_cmplt - c0, 1);
    chk("dn_stop", int'(moving), 0);
    lft_opn = 1'b0; step();

    // fast decel beats simultaneous opening
    go_mv(1'b1);
    repeat (20) vld();
    chk("fast_start", int'(frwrd_spd), 'h2A0);
    frwrd_opn = 1'b0; lft_opn = 1'b1; step();
    c0 = n_cmplt;
    vld();
    chk("fast1", int'(frwrd_spd), 'h240);
    for (int k = 2; k <= 7; k++) begin
      vld();
      chk("fast_dn", int'(frwrd_spd), MAXS - 96 * k);
    end
    step();
    chk("fast_cmplt", n_cmplt - c0, 1);
    chk("fast_stop", int'(moving), 0);
    frwrd_opn = 1'b1; lft_opn = 1'b0; step();

    // opening present at start does not stop
    lft_opn = 1'b1; step();
    go_mv(1'b1);
    repeat (3) vld();
    chk("pre_open", int'(frwrd_spd), 'h118);
    lft_opn = 1'b0; repeat (2) step();
    chk("pre_move", int'(moving), 1);
    lft_opn = 1'b1; step();
    strt_hdng = 1'b1; step(); strt_hdng = 1'b0;
    vld();
    chk("re_open", int'(frwrd_spd), 'h0E8);
    for (int k = 0; k < 20 && moving; k++) vld();
    step();
    chk("re_stop", int'(moving), 0);
    lft_opn = 1'b0; step();

    // simultaneous commands -> heading
    strt_hdng = 1'b1; strt_mv = 1'b1; step();
    strt_hdng = 1'b0; strt_mv = 1'b0;
    chk("both_mov", int'(moving), 1);
    vld();
    chk("both_spd", int'(frwrd_spd), 0);
    at_hdng = 1'b1; vld(); at_hdng = 1'b0;
    chk("both_end", int'(moving), 0);

    // blocked move
    frwrd_opn = 1'b0;
    c0 = n_cmplt;
    go_mv(1'b0);
    chk("blk_cmplt", int'(mv_cmplt), 1);
    chk("blk_mov", int'(moving), 0);
    frwrd_opn = 1'b1; step();

    // reset mid-move, then glitch between edges
    go_mv(1'b0);
    repeat (14) vld();
    chk("pre_rst", int'(frwrd_spd), 'h220);
    c0 = n_cmplt;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst_spd2", int'(frwrd_spd), 0);
    chk("rst_mov2", int'(moving), 0);
    repeat (2) step();
    chk("rst_nocm", n_cmplt - c0, 0);
    go_mv(1'b0);
    repeat (3) vld();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("glitch_spd", int'(frwrd_spd), 'h118);
    chk("glitch_mov", int'(moving), 1);
    frwrd_opn = 1'b0;
    repeat (6) vld();
    step();
    chk("end_stop", int'(moving), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
